// File: rtl/pipe_hop_if.sv
// pipe_hop_if -- stream bundle between a producer, the pipe_hop register
// pipeline and its consumer.
//
// Signals:
//   I        upstream data word
//   I_VALID  upstream word present on I
//   I_READY  pipeline accepts I this cycle
//   O        downstream data word (last pipeline stage)
//   O_VALID  last pipeline stage holds a word
//   O_READY  downstream accepts O this cycle
//   FLUSH    synchronous discard of every held word
//
// Modports:
//   slave  -- the pipeline itself
//   master -- whatever drives the pipeline (producer/consumer pair, bench)
interface pipe_hop_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] I;
  logic             I_VALID;
  logic             I_READY;
  logic [WIDTH-1:0] O;
  logic             O_VALID;
  logic             O_READY;
  logic             FLUSH;

  modport slave (
    input  I, I_VALID, O_READY, FLUSH,
    output I_READY, O, O_VALID
  );

  modport master (
    output I, I_VALID, O_READY, FLUSH,
    input  I_READY, O, O_VALID
  );
endinterface

// File: rtl/pipe_hop.sv
// pipe_hop -- DEPTH-stage valid/ready register pipeline with bubble
// collapsing and a synchronous flush.
//
// Parameters:
//   WIDTH  data bits per word (1..64)
//   DEPTH  register stages between I and O (1..8)
//
// Ports:
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    pipe_hop_if.slave (I/I_VALID/I_READY, O/O_VALID/O_READY, FLUSH)
//   OCC    registered count of valid stages (only with the macro below)
//
// Optional feature:
//   PIPE_HOP_OCCUPANCY_EN  when defined, adds the OCC occupancy counter.
module pipe_hop #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  pipe_hop_if.slave                    bus
`ifdef PIPE_HOP_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]   OCC
`endif
);

  logic [DEPTH-1:0] r_valid;
  logic [WIDTH-1:0] r_data [DEPTH];

  logic [DEPTH-1:0] w_ready;
  logic             w_chain;
  logic [DEPTH-1:0] w_prevValid;
  logic [WIDTH-1:0] w_prevData [DEPTH];
  logic             w_inXfer;

  // Ready chain, walked from the output back towards the input. A stage can
  // load when it is empty or when its word leaves this cycle, and a valid
  // stage leaves exactly when the stage after it can load. That reduces to
  // ready[k] = !valid[k] | ready[k+1], anchored on O_READY at the last stage.
  always_comb begin
    w_chain = ~r_valid[DEPTH-1] | bus.O_READY;
    w_ready[DEPTH-1] = w_chain;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      w_chain = ~r_valid[k] | w_chain;
      w_ready[k] = w_chain;
    end
  end

  // Reset is folded in so I_READY drops the moment rst_n falls, not at the
  // next edge.
  assign bus.I_READY = rst_n & ~bus.FLUSH & w_ready[0];
  assign w_inXfer    = bus.I_VALID & bus.I_READY;

  // What each stage would load: stage 0 takes the accepted input word,
  // every later stage takes its predecessor.
  always_comb begin
    w_prevValid[0] = w_inXfer;
    w_prevData[0]  = bus.I;
    for (int k = 1; k < DEPTH; k++) begin
      w_prevValid[k] = r_valid[k-1];
      w_prevData[k]  = r_data[k-1];
    end
  end

  // Stage registers. Data only moves along with a valid word, so a stalled
  // last stage keeps O steady and an idle stage keeps its old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_data[k] <= '0;
      end
    end else if (bus.FLUSH) begin
      r_valid <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (w_ready[k]) begin
          r_valid[k] <= w_prevValid[k];
          if (w_prevValid[k]) begin
            r_data[k] <= w_prevData[k];
          end
        end
      end
    end
  end

  assign bus.O       = r_data[DEPTH-1];
  assign bus.O_VALID = r_valid[DEPTH-1];

`ifdef PIPE_HOP_OCCUPANCY_EN
  localparam int OccW = $clog2(DEPTH + 1);

  logic [OccW-1:0] r_occ;
  logic            w_outXfer;

  assign w_outXfer = r_valid[DEPTH-1] & bus.O_READY & ~bus.FLUSH;

  // Occupancy tracks accepted words minus delivered words; the ready chain
  // already stops input when full, so the count cannot pass DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else if (bus.FLUSH) begin
      r_occ <= '0;
    end else begin
      r_occ <= r_occ + OccW'(w_inXfer) - OccW'(w_outXfer);
    end
  end

  assign OCC = r_occ;
`endif

endmodule

// File: doc/pipe_hop.md
PIPE_HOP -- requirements
Module: pipe_hop

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data bits per word (1..64).
REQ-002 SHALL have parameter DEPTH, default 2: number of register stages between I and O (1..8).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have port I  input  WIDTH  upstream data word.
REQ-006 SHALL have port I_VALID  input  1  upstream word present on I.
REQ-007 SHALL have port I_READY  output  1  block accepts I this cycle.
REQ-008 SHALL have port O  output  WIDTH  downstream data word; equals the data of the last stage.
REQ-009 SHALL have port O_VALID  output  1  the last stage holds a word.
REQ-010 SHALL have port O_READY  input  1  downstream accepts O this cycle.
REQ-011 SHALL have port FLUSH  input  1  synchronous discard of all held words.

Function
REQ-012 SHALL implement DEPTH stages S0..S(DEPTH-1), each holding a data word and a valid bit; S0 is fed from I, and S(DEPTH-1) drives O/O_VALID.
REQ-013 SHALL define a transfer as VALID&READY high at the same rising edge, on either side.
REQ-014 SHALL let stage k load from stage k-1 (or from I when k=0) when stage k is empty or stage k is moving out in the same cycle; this collapses bubbles.
REQ-015 SHALL drive I_READY = !FLUSH & (!S0.valid | S0 moves this cycle), using a combinational ready chain from O_READY.
REQ-016 SHALL give a word accepted at edge t with no stall O_VALID high after edge t+DEPTH-1, i.e. it is presented DEPTH cycles after acceptance.
REQ-017 SHALL sustain one word per cycle when I_VALID and O_READY are both held high, including when all stages are full.
REQ-018 SHALL preserve word order, with no duplication and no loss.
REQ-019 SHALL hold O stable while O_VALID=1 and O_READY=0.
REQ-020 SHALL, when all stages are full and O_READY=0, drive I_READY=0 in the same cycle.
REQ-021 SHALL, when FLUSH=1 at an edge, clear every valid bit, accept no input, and complete no output transfer; O_VALID=0 in the following cycle.
REQ-022 SHALL give FLUSH priority over simultaneous input and output handshakes.
REQ-023 SHALL keep O_VALID and O independent of I within the same cycle (no combinational forward path).

Reset
REQ-024 SHALL, while rst_n=0, force all valid bits to 0 and all stage data to 0, giving O=0, O_VALID=0 and I_READY=0 immediately.
REQ-025 SHALL discard in-flight words when reset is asserted mid-stream; none SHALL reappear after release.
REQ-026 SHALL raise I_READY in the first cycle after rst_n is released, provided FLUSH=0.

Configuration
REQ-027 SHALL, when macro PIPE_HOP_OCCUPANCY_EN is defined, add output OCC [$clog2(DEPTH+1)-1:0]: a registered count of valid stages, reset to 0.
REQ-028 SHALL update OCC each edge as OCC + in_xfer - out_xfer, and set it to 0 on FLUSH; OCC SHALL never exceed DEPTH.
REQ-029 SHALL, when PIPE_HOP_OCCUPANCY_EN is undefined, have no OCC port and no counter logic; all other behaviour SHALL be identical.

Verification
REQ-030 Latency: DEPTH=2; send 0xA5 with O_READY=1 -> O_VALID rises two cycles after acceptance with O=0xA5, high for one cycle.
REQ-031 Backpressure: DEPTH=3, O_READY=0, stream 0x01,0x02,0x03,0x04 -> 3 words accepted, I_READY=0 on the 4th; after release, O shows 01,02,03,04 in order, one per cycle.
REQ-032 Streaming: DEPTH=4, I_VALID=O_READY=1 for 100 cycles with an incrementing counter -> 100 words out in order, I_READY continuously 1.
REQ-033 Flush: DEPTH=2, pipe full (0x11,0x22), FLUSH=1 with I_VALID=1 and O_READY=1 -> next cycle O_VALID=0, no word delivered or accepted, OCC=0 if enabled.
REQ-034 Reset mid-stream: rst_n low with 2 words in flight -> O_VALID=0 asynchronously; after release, a single new word 0x5A emerges alone.
REQ-035 Occupancy (macro defined): DEPTH=3, push 2 words with O_READY=0 -> OCC=2; then push and pop simultaneously -> OCC stays 2.
